semaforo_ctrl: RTL

SEMAFORO_CTRL -- requirements
Module: semaforo_ctrl

---
 rtl/semaforo_ctrl_if.sv | 30 +++
 rtl/semaforo_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/semaforo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : semaforo_ctrl_if
// Brief    : Control and lamp bundle of the traffic-light controller.
//            The master drives enable, night mode and the pedestrian request.
//            The slave (the controller) drives the lamps, the pending flag
//            and the phase code.
// Revision : 1.0 - initial release
// ============================================================================
interface semaforo_ctrl_if;
  logic       en;
  logic       night;
  logic       ped_req;
  logic       lr;
  logic       ly;
  logic       lg;
  logic       ped_wait;
  logic [1:0] phase;

  modport master (
    output en, night, ped_req,
    input  lr, ly, lg, ped_wait, phase
  );

  modport slave (
    input  en, night, ped_req,
    output lr, ly, lg, ped_wait, phase
  );
endinterface
`default_nettype wire

// File: rtl/semaforo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : semaforo_ctrl
// Brief    : Traffic-light controller. The sequence is RED -> GREEN -> YELLOW,
//            timed in prescaled ticks. A night mode gives flashing yellow.
//            The optional pedestrian request shortens GREEN.
//            Build macro SEMAFORO_PED_EN compiles in the pedestrian logic.
//            When the macro is absent, ped_req is ignored and ped_wait is 0.
// Revision : 1.0 - initial release
// ============================================================================
module semaforo_ctrl #(
  parameter int PRESCALE    = 50000000,
  parameter int T_RED       = 5,
  parameter int T_GREEN     = 3,
  parameter int T_YELLOW    = 1,
  parameter int T_MIN_GREEN = 1,
  parameter int TW          = 8
) (
  input  logic            clk,
  input  logic            rst,
  semaforo_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_RED    = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2,
    S_FLASH  = 2'd3
  } state_t;

  // A prescaler of one cycle still needs a 1-bit counter that never moves.
  localparam int            PW              = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] C_PRE_MAX       = PW'(PRESCALE - 1);
  localparam logic [TW-1:0] C_RED_MAX       = TW'(T_RED - 1);
  localparam logic [TW-1:0] C_GREEN_MAX     = TW'(T_GREEN - 1);
  localparam logic [TW-1:0] C_YELLOW_MAX    = TW'(T_YELLOW - 1);
  localparam logic [TW:0]   C_MIN_GREEN     = (TW+1)'(T_MIN_GREEN);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [TW-1:0] r_pc;
  logic [TW-1:0] w_pc_nxt;
  logic [TW-1:0] w_pc_inc;
  logic [TW:0]   w_pc_p1;
  logic [PW-1:0] r_presc;
  logic          r_flash;
  logic          w_flash_nxt;
  logic          r_ped;
  logic          w_ped_nxt;
  logic          w_ped_go;
  logic          w_tick;
  logic          r_lr;
  logic          r_ly;
  logic          r_lg;

  // Tick fires on the last prescaler count, and only when the controller is running.
  always_comb begin
    w_tick   = bus.en && (r_presc == C_PRE_MAX);
    w_pc_inc = r_pc + TW'(1);
    w_pc_p1  = {1'b0, r_pc} + (TW+1)'(1);
  end

  // Pedestrian early-release qualifier; it is held at 0 when the feature is absent.
`ifdef SEMAFORO_PED_EN
  always_comb begin
    w_ped_go = r_ped && (w_pc_p1 >= C_MIN_GREEN);
  end
`else
  always_comb begin
    w_ped_go = 1'b0;
  end
`endif

  // Next state, phase counter and flash bit. Night beats pedestrian and timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_flash_nxt = r_flash;
    if (w_tick) begin
      if (bus.night && (r_state != S_FLASH)) begin
        w_state_nxt = S_FLASH;
        w_pc_nxt    = '0;
        w_flash_nxt = 1'b1;
      end else begin
        case (r_state)
          S_RED: begin
            if (r_pc == C_RED_MAX) begin
              w_state_nxt = S_GREEN;
              w_pc_nxt    = '0;
            end else begin
              w_pc_nxt = w_pc_inc;
            end
          end
          S_GREEN: begin
            if (w_ped_go || (r_pc == C_GREEN_MAX)) begin
              w_state_nxt = S_YELLOW;
              w_pc_nxt    = '0;
            end else begin
              w_pc_nxt = w_pc_inc;
            end
          end
          S_YELLOW: begin
            if (r_pc == C_YELLOW_MAX) begin
              w_state_nxt = S_RED;
              w_pc_nxt    = '0;
            end else begin
              w_pc_nxt = w_pc_inc;
            end
          end
          S_FLASH: begin
            if (bus.night) begin
              w_flash_nxt = ~r_flash;
            end else begin
              w_state_nxt = S_RED;
              w_pc_nxt    = '0;
              w_flash_nxt = 1'b0;
            end
          end
          default: begin
            w_state_nxt = S_RED;
            w_pc_nxt    = '0;
            w_flash_nxt = 1'b0;
          end
        endcase
      end
    end
  end

  // Pending-request flag. Entry to RED clears it and beats a simultaneous set.
`ifdef SEMAFORO_PED_EN
  always_comb begin
    if ((w_state_nxt == S_RED) && (r_state != S_RED)) begin
      w_ped_nxt = 1'b0;
    end else if (bus.ped_req && (r_state != S_RED)) begin
      w_ped_nxt = 1'b1;
    end else begin
      w_ped_nxt = r_ped;
    end
  end
`else
  always_comb begin
    w_ped_nxt = 1'b0;
  end
`endif

  // Register the state. The lamps are registered alongside it from the same next-state decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RED;
      r_pc    <= '0;
      r_presc <= '0;
      r_flash <= 1'b0;
      r_ped   <= 1'b0;
      r_lr    <= 1'b1;
      r_ly    <= 1'b0;
      r_lg    <= 1'b0;
    end else begin
      if (bus.en) begin
        r_presc <= w_tick ? '0 : (r_presc + PW'(1));
      end
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_flash <= w_flash_nxt;
      r_ped   <= w_ped_nxt;
      r_lr    <= (w_state_nxt == S_RED);
      r_lg    <= (w_state_nxt == S_GREEN);
      r_ly    <= (w_state_nxt == S_YELLOW) || ((w_state_nxt == S_FLASH) && w_flash_nxt);
    end
  end

  assign bus.lr       = r_lr;
  assign bus.ly       = r_ly;
  assign bus.lg       = r_lg;
  assign bus.ped_wait = r_ped;
  assign bus.phase    = r_state;

endmodule
`default_nettype wire
